contention_arbiter_n: RTL and testbench
=======================================

Name: contention_arbiter_n

Overview:
- Parametrised N-channel successor of the 4-input contention tree.
- Arbitrates between N pixel FIFOs. Grants the channel with the highest fill level through a req/ack handshake.
- Forwards the acknowledged pixel to the z-buffer as a one-cycle send pulse.
- Adds a proper grant FSM, an ack timeout, grant-id reporting and a selectable tie-break policy.

Parameters:
- N_CH, 4: number of requesting channels (>=2).
- FILL_WIDTH, 8: width of each channel fill level.
- PIXEL_WIDTH, 8: width of one pixel word.
- ACK_TIMEOUT, 16: cycles to wait for ack before the request is abandoned (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_in  in  N_CH*PIXEL_WIDTH  pixel of channel i at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- fill  in  N_CH*FILL_WIDTH  fill level of channel i at bits [i*FILL_WIDTH +: FILL_WIDTH].
- ack  in  N_CH  channel i acknowledges the request; pix_in slice is valid in the same cycle.
- rdy_z_buffer  in  1  z-buffer can accept a pixel.
- req  out  N_CH  one-hot-or-zero request to channel i.
- send_z_buffer  out  1  one-cycle pulse: pix_out is valid.
- pix_out  out  PIXEL_WIDTH  forwarded pixel.
- grant_id  out  $clog2(N_CH)  index of the last granted channel.
- ack_timeout  out  1  one-cycle pulse: request abandoned without ack.

Behaviour:
- Reset (async, rst=1): state=IDLE; req=0, send_z_buffer=0, pix_out=0, grant_id=0, ack_timeout=0; timeout counter=0.
- Selection (combinational):
  - Candidates are channels with fill!=0. The winner is the maximum fill.
  - Ties go to the lowest index (default policy).
  - No candidate when all fills are 0.
  - Fill compare is unsigned, FILL_WIDTH bits.
- IDLE:
  - If rdy_z_buffer=1 and a candidate exists: latch sel=winner, grant_id<=winner, req<=onehot(winner), counter<=0, go to REQ.
  - Otherwise req stays 0.
- REQ:
  - req[sel] is held and the winner is not re-evaluated.
  - If ack[sel]=1: pix_out<=pix_in[sel], send_z_buffer<=1, req<=0, go to IDLE.
  - Else if rdy_z_buffer=0: req<=0, go to IDLE, no send.
  - Else if counter==ACK_TIMEOUT-1: req<=0, ack_timeout<=1, go to IDLE.
  - Else counter<=counter+1.
- Latency:
  - Winner plus rdy sampled at edge t gives req visible after t.
  - ack sampled at edge k gives send_z_buffer=1 and new pix_out after k, with req=0 in the same cycle.
  - Earliest next req is one cycle later (one IDLE cycle between grants).
- send_z_buffer and ack_timeout are high for exactly one cycle. pix_out holds its value between sends.
- Boundary rules:
  - ack on a non-selected channel is ignored.
  - ack while in IDLE is ignored.
  - ack[sel] with rdy_z_buffer dropping in the same cycle: ack wins and the pixel is sent.
  - ack[sel] on the timeout cycle: ack wins and no timeout pulse is raised.
  - Fill changes during REQ do not affect sel.
  - Asserting rst mid-REQ drops req immediately and sends nothing.
- Invariant: at most one req bit is high at any time.

Optional Feature:
- Macro: CONTENTION_RR_TIE_EN.
- Defined:
  - Ties among equal maximum fills are broken round-robin.
  - A priority pointer starts at 0 after reset.
  - The search begins at pointer and wraps modulo N_CH.
  - On each successful send the pointer becomes (sel+1) mod N_CH.
  - Timeout or rdy drop leaves the pointer unchanged.
- Not defined: fixed lowest-index tie-break, no pointer register.

Test Plan:
- Reset and idle: rst pulse with all fills 0 and rdy_z_buffer=1 → req=0, send_z_buffer=0, pix_out=0 for 20 cycles.
- Max-fill grant:
  - Stimulus: N_CH=4, fill={3,9,5,9} (ch0..3), rdy=1.
  - Response: req=4'b0010 next cycle, grant_id=1.
  - Then ack[1]=1 with pix 0xA5 → send_z_buffer pulses once, pix_out=0xA5, req=0.
- Round-robin tie (CONTENTION_RR_TIE_EN):
  - Stimulus: fill all 7, each grant acked.
  - Response: grant_id sequence 0,1,2,3,0.
  - Without the macro: 0,0,0,0.
- Timeout: ACK_TIMEOUT=16, winner ch2, ack never asserted → req[2] high for exactly 16 cycles, then ack_timeout pulse, req=0, no send.
- rdy drop and wrong ack:
  - In REQ on ch0, ack[3]=1 → ignored, req[0] stays high.
  - Then rdy_z_buffer=0 → req=0 next cycle, send stays 0.
  - Repeat with rdy=0 and ack[0]=1 in the same cycle → send pulses.
- Async reset mid-grant: rst asserted between edges while req[1]=1 → req=0 immediately, no send; after release normal grant resumes.

Source files
------------

// File: rtl/contention_arbiter_n.sv
// N-channel contention arbiter: grants the fullest pixel FIFO via req/ack and forwards its pixel to the z-buffer.
// Define CONTENTION_RR_TIE_EN for round-robin tie-breaking among equal maximum fills (default: lowest index wins).
module contention_arbiter_n #(
    parameter int N_CH        = 4,
    parameter int FILL_WIDTH  = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH*PIXEL_WIDTH-1:0] pix_in,
    input  logic [N_CH*FILL_WIDTH-1:0]  fill,
    input  logic [N_CH-1:0]             ack,
    input  logic                        rdy_z_buffer,
    output logic [N_CH-1:0]             req,
    output logic                        send_z_buffer,
    output logic [PIXEL_WIDTH-1:0]      pix_out,
    output logic [$clog2(N_CH)-1:0]     grant_id,
    output logic                        ack_timeout
);
    localparam int GW = $clog2(N_CH);
    localparam int CW = $clog2(ACK_TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [GW-1:0]          r_sel;
    logic [CW-1:0]          r_cnt;
    logic [FILL_WIDTH-1:0]  w_fill [N_CH];
    logic [PIXEL_WIDTH-1:0] w_pix  [N_CH];
    logic [FILL_WIDTH-1:0]  w_best;
    logic [GW-1:0]          w_win;
    logic                   w_found;
    logic [N_CH-1:0]        w_onehot;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign w_fill[g] = fill[g*FILL_WIDTH +: FILL_WIDTH];
        assign w_pix[g]  = pix_in[g*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

`ifdef CONTENTION_RR_TIE_EN
    logic [GW-1:0] r_ptr;
    logic [GW:0]   w_idx;
    logic [GW-1:0] w_ptr_next;

    // Winner search starting at the priority pointer; strict compare keeps the first hit on a tie.
    always_comb begin
        w_best = {FILL_WIDTH{1'b0}};
        w_win  = {GW{1'b0}};
        w_idx  = {(GW+1){1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            w_idx = {1'b0, r_ptr} + (GW+1)'(k);
            if (w_idx >= (GW+1)'(N_CH)) begin
                w_idx = w_idx - (GW+1)'(N_CH);
            end else begin
                w_idx = w_idx;
            end
            if (w_fill[w_idx[GW-1:0]] > w_best) begin
                w_best = w_fill[w_idx[GW-1:0]];
                w_win  = w_idx[GW-1:0];
            end else begin
                w_best = w_best;
                w_win  = w_win;
            end
        end
    end

    // Pointer successor after a completed send.
    always_comb begin
        if (r_sel == GW'(N_CH - 1)) begin
            w_ptr_next = {GW{1'b0}};
        end else begin
            w_ptr_next = r_sel + GW'(1);
        end
    end
`else
    // Winner search from index 0; strict compare makes the lowest index win ties.
    always_comb begin
        w_best = {FILL_WIDTH{1'b0}};
        w_win  = {GW{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (w_fill[i] > w_best) begin
                w_best = w_fill[i];
                w_win  = GW'(i);
            end else begin
                w_best = w_best;
                w_win  = w_win;
            end
        end
    end
`endif

    assign w_found  = (w_best != {FILL_WIDTH{1'b0}});
    assign w_onehot = {{(N_CH-1){1'b0}}, 1'b1} << w_win;

    // Grant FSM with registered handshake, send and timeout outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sel         <= {GW{1'b0}};
            r_cnt         <= {CW{1'b0}};
            req           <= {N_CH{1'b0}};
            send_z_buffer <= 1'b0;
            pix_out       <= {PIXEL_WIDTH{1'b0}};
            grant_id      <= {GW{1'b0}};
            ack_timeout   <= 1'b0;
`ifdef CONTENTION_RR_TIE_EN
            r_ptr         <= {GW{1'b0}};
`endif
        end else begin
            send_z_buffer <= 1'b0;
            ack_timeout   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rdy_z_buffer && w_found) begin
                        r_sel    <= w_win;
                        grant_id <= w_win;
                        req      <= w_onehot;
                        r_cnt    <= {CW{1'b0}};
                        r_state  <= S_REQ;
                    end else begin
                        req <= {N_CH{1'b0}};
                    end
                end
                S_REQ: begin
                    // Ack takes precedence over both a rdy drop and the timeout cycle.
                    if (ack[r_sel]) begin
                        pix_out       <= w_pix[r_sel];
                        send_z_buffer <= 1'b1;
                        req           <= {N_CH{1'b0}};
                        r_state       <= S_IDLE;
`ifdef CONTENTION_RR_TIE_EN
                        r_ptr         <= w_ptr_next;
`endif
                    end else if (!rdy_z_buffer) begin
                        req     <= {N_CH{1'b0}};
                        r_state <= S_IDLE;
                    end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        req         <= {N_CH{1'b0}};
                        ack_timeout <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    req     <= {N_CH{1'b0}};
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contention_arbiter_n.sv
// Bench for contention_arbiter_n: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_contention_arbiter_n;
    localparam int N  = 4;
    localparam int FW = 8;
    localparam int PW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*PW-1:0] pix_in = '0;
    logic [N*FW-1:0] fill = '0;
    logic [N-1:0]    ack = '0;
    logic            rdy = 1'b0;
    logic [N-1:0]    req;
    logic            send_z_buffer;
    logic [PW-1:0]   pix_out;
    logic [1:0]      grant_id;
    logic            ack_timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit            m_busy;
    int            m_sel;
    int            m_wait;
    int            m_ptr;
    logic [N-1:0]  exp_req;
    logic          exp_send;
    logic          exp_to;
    logic [PW-1:0] exp_pix;
    logic [1:0]    exp_gid;

    contention_arbiter_n #(
        .N_CH(N), .FILL_WIDTH(FW), .PIXEL_WIDTH(PW), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .fill(fill), .ack(ack),
        .rdy_z_buffer(rdy), .req(req), .send_z_buffer(send_z_buffer),
        .pix_out(pix_out), .grant_id(grant_id), .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int fill_of(input int ch);
        return int'(fill[ch*FW +: FW]);
    endfunction

    // Maximum fill first, then the first channel holding it scanning from the pointer.
    function automatic int model_winner();
        int mx = 0;
        for (int i = 0; i < N; i++) if (fill_of(i) > mx) mx = fill_of(i);
        if (mx == 0) return -1;
        for (int k = 0; k < N; k++) if (fill_of((m_ptr + k) % N) == mx) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_wait = 0; m_ptr = 0;
        exp_req = '0; exp_send = 1'b0; exp_to = 1'b0; exp_pix = '0; exp_gid = '0;
    endtask

    task automatic model_edge();
        int w;
        w = model_winner();
        exp_send = 1'b0;
        exp_to   = 1'b0;
        if (m_busy) begin
            if (ack[m_sel]) begin
                exp_pix  = pix_in[m_sel*PW +: PW];
                exp_send = 1'b1;
                m_busy   = 0;
`ifdef CONTENTION_RR_TIE_EN
                m_ptr    = (m_sel + 1) % N;
`endif
            end else if (!rdy) begin
                m_busy = 0;
            end else if (m_wait == TO - 1) begin
                m_busy = 0;
                exp_to = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (rdy && w >= 0) begin
            m_sel   = w;
            exp_gid = 2'(w);
            m_busy  = 1;
            m_wait  = 0;
        end
        exp_req = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    endtask

    task automatic check(input string tag);
        chk({tag, ".req"},  32'(req),           32'(exp_req));
        chk({tag, ".send"}, 32'(send_z_buffer), 32'(exp_send));
        chk({tag, ".pix"},  32'(pix_out),       32'(exp_pix));
        chk({tag, ".gid"},  32'(grant_id),      32'(exp_gid));
        chk({tag, ".to"},   32'(ack_timeout),   32'(exp_to));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int gids [5];
        int exp_gids [5];
        int cnt;
        int sc;
        bit seen;

        // Reset and idle
        fill = '0; rdy = 1'b1; ack = '0;
        do_reset();
        for (int i = 0; i < 20; i++) tick("idle");

        // Max-fill grant then ack
        fill = {8'd9, 8'd5, 8'd9, 8'd3};
        tick("maxfill_grant");
        chk("maxfill_req", 32'(req), 32'h2);
        chk("maxfill_gid", 32'(grant_id), 32'd1);
        pix_in = 32'h00_00_A5_00; ack = 4'b0010;
        tick("maxfill_ack");
        chk("maxfill_send", 32'(send_z_buffer), 32'd1);
        chk("maxfill_pix", 32'(pix_out), 32'hA5);
        ack = '0; fill = '0;
        tick("maxfill_after");
        chk("maxfill_pulse", 32'(send_z_buffer), 32'd0);

        // Tie sequence
        do_reset();
        fill = {8'd7, 8'd7, 8'd7, 8'd7};
`ifdef CONTENTION_RR_TIE_EN
        exp_gids = '{0, 1, 2, 3, 0};
`else
        exp_gids = '{0, 0, 0, 0, 0};
`endif
        for (int g = 0; g < 5; g++) begin
            tick("tie_grant");
            gids[g] = int'(grant_id);
            ack = req;
            pix_in = $urandom;
            tick("tie_ack");
            ack = '0;
        end
        for (int g = 0; g < 5; g++) chk($sformatf("tie_gid%0d", g), 32'(gids[g]), 32'(exp_gids[g]));
        fill = '0;
        tick("tie_drain");

        // Timeout on ch2
        fill = {8'd0, 8'd5, 8'd0, 8'd0};
        cnt = 0; sc = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick("timeout");
            if (send_z_buffer) sc++;
            if (ack_timeout) seen = 1;
            else if (req[2]) cnt++;
        end
        chk("timeout_seen", 32'(seen), 32'd1);
        chk("timeout_req_cycles", 32'(cnt), 32'd16);
        chk("timeout_nosend", 32'(sc), 32'd0);
        chk("timeout_req_low", 32'(req), 32'd0);
        fill = '0;
        tick("timeout_drain");

        // Wrong ack, rdy drop, ack with rdy drop
        fill = {8'd1, 8'd1, 8'd1, 8'd9};
        tick("wrong_grant");
        ack = 4'b1000;
        tick("wrong_ack");
        chk("wrong_ack_req", 32'(req), 32'h1);
        ack = '0; rdy = 1'b0;
        tick("rdy_drop");
        chk("rdy_drop_req", 32'(req), 32'h0);
        chk("rdy_drop_send", 32'(send_z_buffer), 32'd0);
        rdy = 1'b1;
        tick("regrant");
        ack = 4'b0001; rdy = 1'b0; pix_in = 32'h11_22_33_3C;
        tick("ack_rdy_drop");
        chk("ack_rdy_drop_send", 32'(send_z_buffer), 32'd1);
        chk("ack_rdy_drop_pix", 32'(pix_out), 32'h3C);
        ack = '0; rdy = 1'b1; fill = '0;
        tick("ack_rdy_drain");

        // Async reset mid-grant
        fill = {8'd2, 8'd1, 8'd8, 8'd4};
        tick("midrst_grant");
        chk("midrst_req_before", 32'(req), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req_now", 32'(req), 32'h0);
        chk("midrst_send_now", 32'(send_z_buffer), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("midrst_hold");
        @(negedge clk);
        rst = 1'b0;
        tick("midrst_resume");
        chk("midrst_resume_req", 32'(req), 32'h2);
        fill = '0;
        tick("midrst_drain");
        tick("midrst_drain2");

        // Randomized traffic: busy acks first, then sparse acks to hit timeouts
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 600; c++) begin
                for (int ch = 0; ch < N; ch++) begin
                    fill[ch*FW +: FW] = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
                end
                pix_in = $urandom;
                rdy = (ph == 0) ? ($urandom % 10 != 0) : ($urandom % 60 != 0);
                ack = '0;
                if (m_busy && ($urandom % ((ph == 0) ? 4 : 40) == 0)) ack[m_sel] = 1'b1;
                if ($urandom % 5 == 0) ack[$urandom % N] = 1'b1;
                tick("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
